mixer_iq_pipe: RTL and testbench

//  Parametrised, pipelined successor of the IQ mixer between the DSM front-end datapath and the decimation stage.

---
 rtl/mixer_iq_pipe.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_mixer_iq_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_iq_pipe.sv
// -----------------------------------------------------------------------------
// mixer_iq_pipe
//
// Purpose:
//   Three-stage pipelined IQ mixer between the DSM front-end datapath and the
//   decimation stage. Each I/Q sample is weighted by a ternary LO (-1/0/+1),
//   scaled by an unsigned Q0.CW gain, summed (I+Q), rounded half-up and
//   saturated to OUT_W bits. The LO weights come either from the LO_i/LO_q
//   pins or from an internal fs/4 quadrature phase counter.
//
//   Pipeline:
//     S1  apply LO weight (negating the most negative sample saturates)
//     S2  multiply each weighted stream by the gain register
//     S3  sum, round half up, clamp to the output range
//   A sample presented with in_valid in cycle N appears with out_valid in N+3.
//   Bubbles travel through the pipe untouched; mix_o holds between valid
//   results.
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      mixin_i/mixin_q/LO_* valid this cycle
//   mixin_i    in   DW     I sample, signed
//   mixin_q    in   DW     Q sample, signed
//   lo_int     in   1      1: internal fs/4 LO, 0: LO_i/LO_q pins
//   lo_sync    in   1      force internal LO phase to 0 for this sample
//   LO_i       in   2      external I weight: 1x=-1, 01=+1, 00=0
//   LO_q       in   2      external Q weight, same encoding
//   gain       in   CW     new gain value (Q0.CW, unsigned)
//   gain_load  in   1      capture gain into the gain register
//   sat_clr    in   1      clear sticky sat_o
//   out_valid  out  1      mix_o valid
//   mix_o      out  OUT_W  mixed, scaled, saturated result
//   sat_o      out  1      sticky saturation flag
// -----------------------------------------------------------------------------
module mixer_iq_pipe #(
    parameter int              DW       = 15,
    parameter int              CW       = 16,
    parameter int              OUT_W    = 15,
    parameter logic [CW-1:0]   GAIN_RST = 16'h50C3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [DW-1:0]      mixin_i,
    input  logic [DW-1:0]      mixin_q,
    input  logic               lo_int,
    input  logic               lo_sync,
    input  logic [1:0]         LO_i,
    input  logic [1:0]         LO_q,
    input  logic [CW-1:0]      gain,
    input  logic               gain_load,
    input  logic               sat_clr,
    output logic               out_valid,
    output logic [OUT_W-1:0]   mix_o,
    output logic               sat_o
);

    // Product width (DW x (CW+1) signed) and sum width (one growth bit).
    // The output clamp assumes SW > OUT_W, which holds for any sane setting.
    localparam int PW = DW + CW + 1;
    localparam int SW = DW + CW + 2;

    // LO weight codes, in the same encoding as the LO_i/LO_q pins.
    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b10;

    // Input sample range.
    localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

    // Output range expressed at sum width for a direct signed compare.
    localparam logic signed [SW-1:0] O_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] O_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Half an output LSB at sum scale: 2^(CW-1).
    localparam logic [SW-1:0] ROUND_HALF = {{(SW-CW){1'b0}}, 1'b1, {(CW-1){1'b0}}};

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Apply a ternary weight to a sample. Returns {saturated, value}.
    // Bit 1 of the code has priority, so 10 and 11 both mean -1.
    function automatic logic [DW:0] apply_weight(input logic signed [DW-1:0] x,
                                                 input logic [1:0]          code);
        logic [DW:0] res;
        if (code[1]) begin
            if (x == S_MIN) begin
                // -(-2^(DW-1)) does not fit; pin to the positive rail.
                res = {1'b1, S_MAX};
            end else begin
                res = {1'b0, -x};
            end
        end else if (code[0]) begin
            res = {1'b0, x};
        end else begin
            res = {1'b0, {DW{1'b0}}};
        end
        return res;
    endfunction

    // Clamp a rounded sum into the output range. Returns {clamped, value}.
    function automatic logic [OUT_W:0] clamp_out(input logic signed [SW-1:0] r);
        logic [OUT_W:0] res;
        if (r > O_MAX) begin
            res = {1'b1, O_MAX[OUT_W-1:0]};
        end else if (r < O_MIN) begin
            res = {1'b1, O_MIN[OUT_W-1:0]};
        end else begin
            res = {1'b0, r[OUT_W-1:0]};
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [1:0]              phase_r;
    logic [CW-1:0]           gain_reg_r;

    logic [1:0]              phase_eff_s;
    logic [1:0]              int_wi_s;
    logic [1:0]              int_wq_s;
    logic [1:0]              wi_s;
    logic [1:0]              wq_s;
    logic [DW:0]             w_i_res_s;
    logic [DW:0]             w_q_res_s;

    logic                    s1_valid_r;
    logic signed [DW-1:0]    s1_i_r;
    logic signed [DW-1:0]    s1_q_r;
    logic                    s1_sat_r;

    logic signed [PW-1:0]    gain_ext_s;
    logic signed [PW-1:0]    p_i_s;
    logic signed [PW-1:0]    p_q_s;

    logic                    s2_valid_r;
    logic signed [PW-1:0]    s2_pi_r;
    logic signed [PW-1:0]    s2_pq_r;
    logic                    s2_sat_r;

    logic signed [SW-1:0]    sum_s;
    logic signed [SW-1:0]    round_s;
    logic signed [SW-1:0]    shifted_s;
    logic [OUT_W:0]          clamp_res_s;
    logic                    sat_set_s;

    logic                    out_valid_r;
    logic [OUT_W-1:0]        mix_r;
    logic                    sat_r;

    // -------------------------------------------------------------------------
    // LO weight selection
    // -------------------------------------------------------------------------

    // Internal fs/4 LO: lo_sync forces phase 0 for the current sample.
    always_comb begin
        int_wi_s = W_ZERO;
        int_wq_s = W_ZERO;
        if (lo_sync) begin
            phase_eff_s = 2'd0;
        end else begin
            phase_eff_s = phase_r;
        end
        case (phase_eff_s)
            2'd0: begin int_wi_s = W_POS;  int_wq_s = W_ZERO; end
            2'd1: begin int_wi_s = W_ZERO; int_wq_s = W_POS;  end
            2'd2: begin int_wi_s = W_NEG;  int_wq_s = W_ZERO; end
            2'd3: begin int_wi_s = W_ZERO; int_wq_s = W_NEG;  end
            default: begin int_wi_s = W_ZERO; int_wq_s = W_ZERO; end
        endcase
    end

    // Choose between the internal LO and the external LO pins.
    always_comb begin
        if (lo_int) begin
            wi_s = int_wi_s;
            wq_s = int_wq_s;
        end else begin
            wi_s = LO_i;
            wq_s = LO_q;
        end
    end

    // Phase counter: advances on valid samples only; resync restarts at 0 so
    // the next sample (if this one is valid) sees phase 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= 2'd0;
        end else if (lo_int) begin
            if (lo_sync) begin
                phase_r <= in_valid ? 2'd1 : 2'd0;
            end else if (in_valid) begin
                phase_r <= phase_r + 2'd1;
            end else begin
                phase_r <= phase_r;
            end
        end else begin
            phase_r <= phase_r;
        end
    end

    // Gain register: a load takes effect for samples entering S2 after the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gain_reg_r <= GAIN_RST;
        end else if (gain_load) begin
            gain_reg_r <= gain;
        end else begin
            gain_reg_r <= gain_reg_r;
        end
    end

    // -------------------------------------------------------------------------
    // S1: weight application
    // -------------------------------------------------------------------------
    assign w_i_res_s = apply_weight($signed(mixin_i), wi_s);
    assign w_q_res_s = apply_weight($signed(mixin_q), wq_s);

    // S1 register; data only updates on valid slots, flags follow the slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_i_r     <= {DW{1'b0}};
            s1_q_r     <= {DW{1'b0}};
            s1_sat_r   <= 1'b0;
        end else if (in_valid) begin
            s1_valid_r <= 1'b1;
            s1_i_r     <= w_i_res_s[DW-1:0];
            s1_q_r     <= w_q_res_s[DW-1:0];
            s1_sat_r   <= w_i_res_s[DW] | w_q_res_s[DW];
        end else begin
            s1_valid_r <= 1'b0;
            s1_i_r     <= s1_i_r;
            s1_q_r     <= s1_q_r;
            s1_sat_r   <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // S2: gain multiply (gain zero-extended, operands widened to PW so the
    // signed product is exact at PW bits)
    // -------------------------------------------------------------------------
    assign gain_ext_s = $signed({{(PW-CW){1'b0}}, gain_reg_r});
    assign p_i_s = $signed({{(PW-DW){s1_i_r[DW-1]}}, s1_i_r}) * gain_ext_s;
    assign p_q_s = $signed({{(PW-DW){s1_q_r[DW-1]}}, s1_q_r}) * gain_ext_s;

    // S2 register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
            s2_pi_r    <= {PW{1'b0}};
            s2_pq_r    <= {PW{1'b0}};
            s2_sat_r   <= 1'b0;
        end else if (s1_valid_r) begin
            s2_valid_r <= 1'b1;
            s2_pi_r    <= p_i_s;
            s2_pq_r    <= p_q_s;
            s2_sat_r   <= s1_sat_r;
        end else begin
            s2_valid_r <= 1'b0;
            s2_pi_r    <= s2_pi_r;
            s2_pq_r    <= s2_pq_r;
            s2_sat_r   <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // S3: sum, round half up, clamp
    // -------------------------------------------------------------------------
    assign sum_s       = $signed({s2_pi_r[PW-1], s2_pi_r}) + $signed({s2_pq_r[PW-1], s2_pq_r});
    assign round_s     = sum_s + $signed(ROUND_HALF);
    assign shifted_s   = round_s >>> CW;
    assign clamp_res_s = clamp_out(shifted_s);

    // Saturation from either S1 negation or S3 clamp, only for real samples.
    assign sat_set_s = s2_valid_r & (s2_sat_r | clamp_res_s[OUT_W]);

    // Output register: mix_o holds its last value through bubbles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            mix_r       <= {OUT_W{1'b0}};
        end else if (s2_valid_r) begin
            out_valid_r <= 1'b1;
            mix_r       <= clamp_res_s[OUT_W-1:0];
        end else begin
            out_valid_r <= 1'b0;
            mix_r       <= mix_r;
        end
    end

    // Sticky saturation flag; a new saturation beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_r <= 1'b0;
        end else begin
            sat_r <= sat_set_s | (sat_r & ~sat_clr);
        end
    end

    assign out_valid = out_valid_r;
    assign mix_o     = mix_r;
    assign sat_o     = sat_r;

endmodule

// File: tb/tb_mixer_iq_pipe.sv
// -----------------------------------------------------------------------------
// tb_mixer_iq_pipe
//
// Directed self-checking bench for mixer_iq_pipe. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_mixer_iq_pipe;

    localparam int DW    = 15;
    localparam int CW    = 16;
    localparam int OUT_W = 15;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic [DW-1:0]    mixin_i;
    logic [DW-1:0]    mixin_q;
    logic             lo_int;
    logic             lo_sync;
    logic [1:0]       LO_i;
    logic [1:0]       LO_q;
    logic [CW-1:0]    gain;
    logic             gain_load;
    logic             sat_clr;
    logic             out_valid;
    logic [OUT_W-1:0] mix_o;
    logic             sat_o;

    int checks   = 0;
    int failures = 0;

    mixer_iq_pipe #(
        .DW       (DW),
        .CW       (CW),
        .OUT_W    (OUT_W),
        .GAIN_RST (16'h50C3)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .mixin_i   (mixin_i),
        .mixin_q   (mixin_q),
        .lo_int    (lo_int),
        .lo_sync   (lo_sync),
        .LO_i      (LO_i),
        .LO_q      (LO_q),
        .gain      (gain),
        .gain_load (gain_load),
        .sat_clr   (sat_clr),
        .out_valid (out_valid),
        .mix_o     (mix_o),
        .sat_o     (sat_o)
    );

    always #5 clock = ~clock;

    function automatic logic [OUT_W-1:0] to_o(input int v);
        return v[OUT_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int i, input int q,
                         input logic [1:0] li, input logic [1:0] lq);
        in_valid = v;
        mixin_i  = i[DW-1:0];
        mixin_q  = q[DW-1:0];
        LO_i     = li;
        LO_q     = lq;
    endtask

    task automatic load_gain(input logic [CW-1:0] g);
        gain      = g;
        gain_load = 1'b1;
        tick();
        gain_load = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (mix_o !== to_o(0)) begin failures++; $display("FAIL reset_mix got=%0d exp=0", $signed(mix_o)); end
        checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", sat_o); end
        reset_n = 1'b1;
        tick();
    endtask

    // T1: single pulse, exact 3-cycle latency.
    task automatic test_basic();
        load_gain(16'h8000);
        drive(1'b1, 1000, 2000, 2'b01, 2'b01);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_lat1 out_valid got=%0b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_lat2 out_valid got=%0b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t1_lat3 out_valid got=%0b exp=1", out_valid); end
        checks++; if (mix_o !== to_o(1500)) begin failures++; $display("FAIL t1_mix got=%0d exp=1500", $signed(mix_o)); end
        checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL t1_sat got=%0b exp=0", sat_o); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_after out_valid got=%0b exp=0", out_valid); end
        checks++; if (mix_o !== to_o(1500)) begin failures++; $display("FAIL t1_hold got=%0d exp=1500", $signed(mix_o)); end
    endtask

    // Round half up at gain 0.5: +0.5 -> 1, -0.5 -> 0.
    task automatic test_rounding();
        drive(1'b1, 1, 0, 2'b01, 2'b00);
        tick(); in_valid = 1'b0; tick(); tick();
        checks++; if (mix_o !== to_o(1) || out_valid !== 1'b1) begin failures++; $display("FAIL round_pos got=%0d/%0b exp=1/1", $signed(mix_o), out_valid); end
        drive(1'b1, -1, 0, 2'b01, 2'b00);
        tick(); in_valid = 1'b0; tick(); tick();
        checks++; if (mix_o !== to_o(0) || out_valid !== 1'b1) begin failures++; $display("FAIL round_neg got=%0d/%0b exp=0/1", $signed(mix_o), out_valid); end
    endtask

    // T2/T3: output clamp, negation clamp, sticky flag, clear priority, bubbles.
    task automatic test_saturation();
        load_gain(16'hFFFF);
        drive(1'b1, 16383, 16383, 2'b01, 2'b01);
        tick(); in_valid = 1'b0; tick(); tick();
        checks++; if (mix_o !== to_o(16383)) begin failures++; $display("FAIL t2_mix got=%0d exp=16383", $signed(mix_o)); end
        checks++; if (sat_o !== 1'b1) begin failures++; $display("FAIL t2_sat got=%0b exp=1", sat_o); end
        tick(); tick(); tick();
        checks++; if (sat_o !== 1'b1) begin failures++; $display("FAIL t2_sticky got=%0b exp=1", sat_o); end
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL t2_clear got=%0b exp=0", sat_o); end
        // A would-be negation overflow in a bubble slot must not flag.
        drive(1'b0, -16384, 0, 2'b10, 2'b00);
        tick(); tick(); tick(); tick();
        checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL bubble_sat got=%0b exp=0", sat_o); end
        // T3: -1 * -16384 clamps to 16383 before the multiply.
        drive(1'b1, -16384, 0, 2'b10, 2'b00);
        tick(); in_valid = 1'b0; tick(); tick();
        checks++; if (mix_o !== to_o(16383)) begin failures++; $display("FAIL t3_mix got=%0d exp=16383", $signed(mix_o)); end
        checks++; if (sat_o !== 1'b1) begin failures++; $display("FAIL t3_sat got=%0b exp=1", sat_o); end
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL t3_clear got=%0b exp=0", sat_o); end
        // LO code 11 also means -1.
        drive(1'b1, 300, 0, 2'b11, 2'b00);
        tick(); in_valid = 1'b0; tick(); tick();
        checks++; if (mix_o !== to_o(-300)) begin failures++; $display("FAIL lo11_mix got=%0d exp=-300", $signed(mix_o)); end
        // Clear coinciding with a new saturation: set wins.
        drive(1'b1, 16383, 16383, 2'b01, 2'b01);
        tick(); in_valid = 1'b0; tick();
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        checks++; if (sat_o !== 1'b1) begin failures++; $display("FAIL set_vs_clr got=%0b exp=1", sat_o); end
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL final_clear got=%0b exp=0", sat_o); end
    endtask

    // T4: internal fs/4 LO with resync and a 2-cycle valid gap.
    task automatic test_internal_lo();
        logic v_tab [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int   m_tab [10] = '{50, 100, -50, -100, 50, 50, 50, 100, -50, -100};
        load_gain(16'h8000);
        lo_int = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t < 10) begin
                drive(v_tab[t], 100, 200, 2'b00, 2'b00);
                lo_sync = (t == 0) ? 1'b1 : 1'b0;
            end else begin
                in_valid = 1'b0;
                lo_sync  = 1'b0;
            end
            tick();
            if (t >= 2) begin
                checks++; if (out_valid !== v_tab[t-2]) begin failures++; $display("FAIL t4_valid[%0d] got=%0b exp=%0b", t-2, out_valid, v_tab[t-2]); end
                checks++; if (mix_o !== to_o(m_tab[t-2])) begin failures++; $display("FAIL t4_mix[%0d] got=%0d exp=%0d", t-2, $signed(mix_o), m_tab[t-2]); end
            end
        end
        lo_int = 1'b0;
    endtask

    // T5: gain change mid-stream lands on the sample presented with the load.
    task automatic test_gain_switch();
        int m_tab [7] = '{200, 200, 200, 100, 100, 100, 100};
        gain = 16'h4000;
        for (int t = 0; t < 9; t++) begin
            if (t < 7) begin
                drive(1'b1, 400, 0, 2'b01, 2'b00);
            end else begin
                in_valid = 1'b0;
            end
            gain_load = (t == 3) ? 1'b1 : 1'b0;
            tick();
            if (t >= 2) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t5_valid[%0d] got=%0b exp=1", t-2, out_valid); end
                checks++; if (mix_o !== to_o(m_tab[t-2])) begin failures++; $display("FAIL t5_mix[%0d] got=%0d exp=%0d", t-2, $signed(mix_o), m_tab[t-2]); end
            end
        end
        gain_load = 1'b0;
    endtask

    // T6: asynchronous reset with a full pipeline, then restart defaults.
    task automatic test_async_reset();
        drive(1'b1, -16384, 0, 2'b10, 2'b00);
        tick(); tick(); tick(); tick();
        checks++; if (out_valid !== 1'b1 || sat_o !== 1'b1) begin failures++; $display("FAIL t6_prefill got=%0b/%0b exp=1/1", out_valid, sat_o); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t6_async_valid got=%0b exp=0", out_valid); end
        checks++; if (mix_o !== to_o(0)) begin failures++; $display("FAIL t6_async_mix got=%0d exp=0", $signed(mix_o)); end
        checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL t6_async_sat got=%0b exp=0", sat_o); end
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        // Default gain 0x50C3: 1000*20675/65536 = 315.47 -> 315.
        drive(1'b1, 1000, 0, 2'b01, 2'b00);
        tick(); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t6_lat1 got=%0b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t6_lat2 got=%0b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t6_lat3 got=%0b exp=1", out_valid); end
        checks++; if (mix_o !== to_o(315)) begin failures++; $display("FAIL t6_default_gain got=%0d exp=315", $signed(mix_o)); end
        // Phase restarted at 0: first internal-LO sample uses weight (+1,0).
        load_gain(16'h8000);
        lo_int = 1'b1;
        drive(1'b1, 100, 200, 2'b00, 2'b00);
        tick(); in_valid = 1'b0; tick(); tick();
        checks++; if (mix_o !== to_o(50)) begin failures++; $display("FAIL t6_phase0 got=%0d exp=50", $signed(mix_o)); end
        lo_int = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        mixin_i   = {DW{1'b0}};
        mixin_q   = {DW{1'b0}};
        lo_int    = 1'b0;
        lo_sync   = 1'b0;
        LO_i      = 2'b00;
        LO_q      = 2'b00;
        gain      = {CW{1'b0}};
        gain_load = 1'b0;
        sat_clr   = 1'b0;

        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_internal_lo();
        test_gain_switch();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
